// File: rtl/mbed_frame_packer_pkg.sv
// Shared definitions for the MBED frame packer: FSM state encoding,
// parameter defaults and the sample-word helper.
package mbed_frame_packer_pkg;

  // Frame sequencer states, in transmit order.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    SEQ  = 3'd2,
    DATA = 3'd3,
    CSUM = 3'd4
  } state_t;

  localparam int          FRAME_LEN_DEF = 64;
  localparam logic [15:0] SYNC_WORD_DEF = 16'hA5A5;
  localparam int          CNT_W         = 10;

  // ADC words are sent right-shifted by one with a zero MSB.
  function automatic logic [15:0] shift_sample(input logic [15:0] w);
    return w >> 1;
  endfunction

endpackage

// File: rtl/mbed_frame_packer_rise_edge_det.sv
// One-bit rising-edge detector: a single history register, pulse when the
// input is high now and was low on the previous clock.
module rise_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic prev_r;

  // Remember the input level from the previous clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_r <= 1'b0;
    end else begin
      prev_r <= d;
    end
  end

  assign rise = d & ~prev_r;

endmodule

// File: rtl/mbed_frame_packer.sv
// Frame packer: pulls ADC samples from a show-ahead FIFO and feeds an SPI
// master one word at a time as SYNC, sequence number, FRAME_LEN samples
// and a 16-bit additive checksum of the transmitted samples.
module mbed_frame_packer
  import mbed_frame_packer_pkg::*;
#(
  parameter int          FRAME_LEN = FRAME_LEN_DEF,
  parameter logic [15:0] SYNC_WORD = SYNC_WORD_DEF
) (
  input  logic        SYS_CLK,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        mbed_rdy,
  input  logic        fifo_empty,
  input  logic [15:0] fifo_dout,
  output logic        fifo_rd,
  input  logic        spi_fin,
  output logic        spi_ena,
  output logic [15:0] spi_data,
  output logic        frame_active,
  output logic [15:0] frame_count
);

  // Counter value at which the final sample of the frame is being loaded.
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  state_t             state_r,        state_s;
  logic               spi_ena_r,      spi_ena_s;
  logic [15:0]        spi_data_r,     spi_data_s;
  logic               fifo_rd_r,      fifo_rd_s;
  logic               frame_active_r, frame_active_s;
  logic [15:0]        frame_count_r,  frame_count_s;
  logic [CNT_W-1:0]   sample_cnt_r,   sample_cnt_s;
  logic               last_r,         last_s;
  logic               load_pend_r,    load_pend_s;
  logic [15:0]        csum_r,         csum_s;

  logic               fin_rise_s;
  logic               fin_evt_s;
  logic               load_pt_s;
  logic [15:0]        sample_s;

  rise_edge_det u_fin_det (
    .clk   (SYS_CLK),
    .rst_n (reset_n),
    .d     (spi_fin),
    .rise  (fin_rise_s)
  );

  // A finish edge only counts while a word is actually in flight.
  assign fin_evt_s = fin_rise_s & spi_ena_r;
  assign sample_s  = shift_sample(fifo_dout);

  // Next-state, handshake, sample load and checksum logic.
  always_comb begin
    state_s        = state_r;
    spi_ena_s      = spi_ena_r;
    spi_data_s     = spi_data_r;
    fifo_rd_s      = 1'b0;
    frame_active_s = frame_active_r;
    frame_count_s  = frame_count_r;
    sample_cnt_s   = sample_cnt_r;
    last_s         = last_r;
    load_pend_s    = load_pend_r;
    csum_s         = csum_r;
    load_pt_s      = 1'b0;

    if (!enable) begin
      // Abort: drop the partial frame, keep the completed-frame count.
      state_s        = IDLE;
      spi_ena_s      = 1'b0;
      load_pend_s    = 1'b0;
      frame_active_s = 1'b0;
      sample_cnt_s   = {CNT_W{1'b0}};
      last_s         = 1'b0;
      csum_s         = 16'h0000;
    end else begin
      // spi_ena rises the cycle after a load and falls after a finish edge,
      // which guarantees at least one low cycle between words.
      if (load_pend_r) begin
        spi_ena_s   = 1'b1;
        load_pend_s = 1'b0;
      end else if (fin_evt_s) begin
        spi_ena_s = 1'b0;
      end else begin
        spi_ena_s = spi_ena_r;
      end

      case (state_r)
        IDLE: begin
          if (mbed_rdy && !fifo_empty) begin
            state_s        = HDR;
            spi_data_s     = SYNC_WORD;
            load_pend_s    = 1'b1;
            frame_active_s = 1'b1;
            sample_cnt_s   = {CNT_W{1'b0}};
            last_s         = 1'b0;
            csum_s         = 16'h0000;
          end else begin
            state_s = IDLE;
          end
        end
        HDR: begin
          if (fin_evt_s) begin
            state_s     = SEQ;
            spi_data_s  = frame_count_r;
            load_pend_s = 1'b1;
          end else begin
            state_s = HDR;
          end
        end
        SEQ: begin
          if (fin_evt_s) begin
            state_s = DATA;
          end else begin
            state_s = SEQ;
          end
        end
        DATA: begin
          if (fin_evt_s && last_r) begin
            state_s     = CSUM;
            spi_data_s  = csum_r;
            load_pend_s = 1'b1;
          end else begin
            state_s = DATA;
          end
        end
        CSUM: begin
          if (fin_evt_s) begin
            state_s        = IDLE;
            frame_count_s  = frame_count_r + 16'd1;
            frame_active_s = 1'b0;
          end else begin
            state_s = CSUM;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase

      // A sample is due right after the sequence word, after each
      // non-final sample, or while stalled on an empty FIFO.
      load_pt_s = ((state_r == SEQ) && fin_evt_s) ||
                  ((state_r == DATA) && !last_r &&
                   (fin_evt_s || (!spi_ena_r && !load_pend_r)));

      if (load_pt_s && !fifo_empty) begin
        spi_data_s   = sample_s;
        fifo_rd_s    = 1'b1;
        load_pend_s  = 1'b1;
        csum_s       = csum_r + sample_s;
        sample_cnt_s = sample_cnt_r + CNT_W'(1);
        last_s       = (sample_cnt_r == LAST_IDX);
      end else begin
        fifo_rd_s = 1'b0;
      end
    end
  end

  // State and output registers; everything clears on reset.
  always_ff @(posedge SYS_CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_r        <= IDLE;
      spi_ena_r      <= 1'b0;
      spi_data_r     <= 16'h0000;
      fifo_rd_r      <= 1'b0;
      frame_active_r <= 1'b0;
      frame_count_r  <= 16'h0000;
      sample_cnt_r   <= {CNT_W{1'b0}};
      last_r         <= 1'b0;
      load_pend_r    <= 1'b0;
      csum_r         <= 16'h0000;
    end else begin
      state_r        <= state_s;
      spi_ena_r      <= spi_ena_s;
      spi_data_r     <= spi_data_s;
      fifo_rd_r      <= fifo_rd_s;
      frame_active_r <= frame_active_s;
      frame_count_r  <= frame_count_s;
      sample_cnt_r   <= sample_cnt_s;
      last_r         <= last_s;
      load_pend_r    <= load_pend_s;
      csum_r         <= csum_s;
    end
  end

  assign spi_ena      = spi_ena_r;
  assign spi_data     = spi_data_r;
  assign fifo_rd      = fifo_rd_r;
  assign frame_active = frame_active_r;
  assign frame_count  = frame_count_r;

endmodule

// File: tb/tb_mbed_frame_packer.sv
// Self-checking bench for mbed_frame_packer with FRAME_LEN=4: table-driven
// frames plus directed stall, abort, wrap and async-reset sequences.
module tb_mbed_frame_packer;

  logic        SYS_CLK = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        mbed_rdy;
  logic        fifo_empty = 1'b1;
  logic [15:0] fifo_dout  = 16'h0000;
  logic        fifo_rd;
  logic        spi_fin    = 1'b0;
  logic        spi_ena;
  logic [15:0] spi_data;
  logic        frame_active;
  logic [15:0] frame_count;

  mbed_frame_packer #(.FRAME_LEN(4), .SYNC_WORD(16'hA5A5)) dut (
    .SYS_CLK      (SYS_CLK),
    .reset_n      (reset_n),
    .enable       (enable),
    .mbed_rdy     (mbed_rdy),
    .fifo_empty   (fifo_empty),
    .fifo_dout    (fifo_dout),
    .fifo_rd      (fifo_rd),
    .spi_fin      (spi_fin),
    .spi_ena      (spi_ena),
    .spi_data     (spi_data),
    .frame_active (frame_active),
    .frame_count  (frame_count)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  int n_pass = 0;
  int n_chk  = 0;

  // ---------------- FIFO model (show-ahead) ----------------
  logic [15:0] fifo_q[$];
  int rd_count       = 0;
  int rd_empty_count = 0;

  // Pop on each fifo_rd strobe; record any strobe while empty.
  always @(posedge SYS_CLK) begin
    if (fifo_rd) begin
      rd_count <= rd_count + 1;
      if (fifo_empty) rd_empty_count <= rd_empty_count + 1;
      else void'(fifo_q.pop_front());
    end
  end

  // Present the head word and empty flag away from the rising edge.
  always @(negedge SYS_CLK) begin
    fifo_empty <= (fifo_q.size() == 0);
    fifo_dout  <= (fifo_q.size() == 0) ? 16'h0000 : fifo_q[0];
  end

  // ---------------- SPI master model ----------------
  logic        ena_prev = 1'b0;
  int          spi_cnt  = 0;
  logic [15:0] cap_q[$];

  // Capture each word as spi_ena rises, finish 16 cycles later.
  always @(negedge SYS_CLK) begin
    ena_prev <= spi_ena;
    if (spi_ena && !ena_prev) cap_q.push_back(spi_data);
    if (!spi_ena) begin
      spi_cnt <= 0;
      spi_fin <= 1'b0;
    end else if (!spi_fin) begin
      if (spi_cnt == 15) spi_fin <= 1'b1;
      else spi_cnt <= spi_cnt + 1;
    end
  end

  // ---------------- vectors ----------------
  typedef struct packed {
    logic [15:0] s0, s1, s2, s3;
    logic [15:0] w0, w1, w2, w3;
    logic [15:0] cs;
  } vec_t;

  vec_t        vecs[4];
  vec_t        v_stall;
  logic [15:0] exp_fc = 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic push4(input vec_t v);
    fifo_q.push_back(v.s0);
    fifo_q.push_back(v.s1);
    fifo_q.push_back(v.s2);
    fifo_q.push_back(v.s3);
  endtask

  task automatic wait_frame(input int budget, output bit ok);
    bit seen;
    ok = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge SYS_CLK);
      if (frame_active) seen = 1'b1;
      else if (seen) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_frame(input string tag, input vec_t v, input logic [15:0] seq);
    logic [15:0] ew[7];
    logic [31:0] act;
    ew[0] = 16'hA5A5; ew[1] = seq;
    ew[2] = v.w0; ew[3] = v.w1; ew[4] = v.w2; ew[5] = v.w3; ew[6] = v.cs;
    check({tag, " nwords"}, cap_q.size(), 32'd7);
    for (int k = 0; k < 7; k++) begin
      act = (k < cap_q.size()) ? {16'h0000, cap_q[k]} : 32'hFFFF_FFFF;
      check($sformatf("%s word%0d", tag, k), act, {16'h0000, ew[k]});
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int rd0;
    bit ok;
    logic [15:0] seq;
    seq = exp_fc;
    rd0 = rd_count;
    @(posedge SYS_CLK);
    push4(v);
    cap_q.delete();
    enable   = 1'b1;
    mbed_rdy = 1'b1;
    wait_frame(600, ok);
    check({tag, " done"}, ok, 1);
    repeat (2) @(negedge SYS_CLK);
    check_frame(tag, v, seq);
    check({tag, " rd pulses"}, rd_count - rd0, 32'd4);
    exp_fc = exp_fc + 16'd1;
    check({tag, " frame_count"}, frame_count, exp_fc);
    check({tag, " rd while empty"}, rd_empty_count, 32'd0);
  endtask

  initial begin
    int  rd0;
    int  rd1;
    bit  ok;
    bit  ena_hi;

    vecs[0] = '{s0:16'h0002, s1:16'h0004, s2:16'h0006, s3:16'h0008,
                w0:16'h0001, w1:16'h0002, w2:16'h0003, w3:16'h0004, cs:16'h000A};
    vecs[1] = '{s0:16'hFFFE, s1:16'hFFFE, s2:16'hFFFE, s3:16'hFFFE,
                w0:16'h7FFF, w1:16'h7FFF, w2:16'h7FFF, w3:16'h7FFF, cs:16'hFFFC};
    vecs[2] = '{s0:16'h1235, s1:16'h8001, s2:16'h0000, s3:16'hABCD,
                w0:16'h091A, w1:16'h4000, w2:16'h0000, w3:16'h55E6, cs:16'h9F00};
    vecs[3] = '{s0:16'hFFFF, s1:16'hFFFF, s2:16'h8000, s3:16'h0001,
                w0:16'h7FFF, w1:16'h7FFF, w2:16'h4000, w3:16'h0000, cs:16'h3FFE};
    v_stall = '{s0:16'h0010, s1:16'h0020, s2:16'h0030, s3:16'h0040,
                w0:16'h0008, w1:16'h0010, w2:16'h0018, w3:16'h0020, cs:16'h0050};

    reset_n  = 1'b0;
    enable   = 1'b0;
    mbed_rdy = 1'b0;

    // Reset state
    repeat (3) @(negedge SYS_CLK);
    check("rst spi_ena", spi_ena, 1'b0);
    check("rst fifo_rd", fifo_rd, 1'b0);
    check("rst spi_data", spi_data, 16'h0000);
    check("rst frame_active", frame_active, 1'b0);
    check("rst frame_count", frame_count, 16'h0000);
    reset_n = 1'b1;
    repeat (2) @(negedge SYS_CLK);

    // Table-driven frames
    for (int i = 0; i < 4; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // FIFO underrun stall mid-frame
    rd0 = rd_count;
    @(posedge SYS_CLK);
    fifo_q.push_back(v_stall.s0);
    fifo_q.push_back(v_stall.s1);
    cap_q.delete();
    repeat (100) @(posedge SYS_CLK);
    @(negedge SYS_CLK);
    check("stall spi_ena", spi_ena, 1'b0);
    check("stall frame_active", frame_active, 1'b1);
    check("stall rd pulses", rd_count - rd0, 32'd2);
    check("stall words so far", cap_q.size(), 32'd4);
    ena_hi = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge SYS_CLK);
      if (spi_ena) ena_hi = 1'b1;
    end
    check("stall spi_ena held low", ena_hi, 1'b0);
    @(posedge SYS_CLK);
    fifo_q.push_back(v_stall.s2);
    fifo_q.push_back(v_stall.s3);
    wait_frame(600, ok);
    check("stall done", ok, 1);
    repeat (2) @(negedge SYS_CLK);
    check_frame("stall", v_stall, exp_fc);
    check("stall total rd", rd_count - rd0, 32'd4);
    check("stall rd while empty", rd_empty_count, 32'd0);
    exp_fc = exp_fc + 16'd1;
    check("stall frame_count", frame_count, exp_fc);

    // Abort during the second sample
    rd0 = rd_count;
    @(posedge SYS_CLK);
    push4(vecs[0]);
    cap_q.delete();
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge SYS_CLK);
      if (rd_count - rd0 == 2) begin
        ok = 1'b1;
        break;
      end
    end
    check("abort reached 2nd sample", ok, 1);
    enable = 1'b0;
    @(posedge SYS_CLK);
    #1;
    check("abort spi_ena", spi_ena, 1'b0);
    check("abort frame_active", frame_active, 1'b0);
    check("abort fifo_rd", fifo_rd, 1'b0);
    check("abort frame_count", frame_count, exp_fc);
    repeat (20) @(negedge SYS_CLK);
    check("abort no more rd", rd_count - rd0, 32'd2);
    @(posedge SYS_CLK);
    fifo_q.delete();
    run_vec("restart", vecs[2]);

    // Sequence-number wrap
    enable = 1'b0;
    @(negedge SYS_CLK);
    force dut.frame_count_r = 16'hFFFF;
    @(negedge SYS_CLK);
    release dut.frame_count_r;
    @(negedge SYS_CLK);
    check("wrap preload", frame_count, 16'hFFFF);
    exp_fc = 16'hFFFF;
    run_vec("wrap", vecs[3]);

    // Asynchronous reset in the middle of DATA
    rd0 = rd_count;
    @(posedge SYS_CLK);
    push4(vecs[1]);
    cap_q.delete();
    enable   = 1'b1;
    mbed_rdy = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge SYS_CLK);
      if (rd_count - rd0 >= 1) begin
        ok = 1'b1;
        break;
      end
    end
    check("mid reached DATA", ok, 1);
    repeat (3) @(negedge SYS_CLK);
    #3;
    reset_n = 1'b0;
    #1;
    check("arst spi_ena", spi_ena, 1'b0);
    check("arst fifo_rd", fifo_rd, 1'b0);
    check("arst spi_data", spi_data, 16'h0000);
    check("arst frame_active", frame_active, 1'b0);
    check("arst frame_count", frame_count, 16'h0000);
    mbed_rdy = 1'b0;
    @(negedge SYS_CLK);
    reset_n = 1'b1;
    rd1 = rd_count;
    repeat (30) @(negedge SYS_CLK);
    check("post-rst no rd", rd_count - rd1, 32'd0);
    check("post-rst idle", frame_active, 1'b0);
    check("post-rst spi_ena", spi_ena, 1'b0);
    @(posedge SYS_CLK);
    fifo_q.delete();
    exp_fc = 16'h0000;
    run_vec("post-rst", vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
